// File: rtl/proc_field_serializer_if.sv
// Stream bundle for the field serializer: word-wide push side, field-wide pop side.
// The master modport drives the pushes and takes the fields; the slave modport is the serializer.
interface proc_field_serializer_if #(
  parameter int FIELD_W    = 2,
  parameter int NUM_FIELDS = 4,
  parameter int DEPTH      = 4
);
  logic [FIELD_W*NUM_FIELDS-1:0] in_word;
  logic                          in_valid;
  logic                          in_ready;
  logic [FIELD_W-1:0]            out_field;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic [$clog2(DEPTH):0]        count;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_field, out_valid, out_last, count
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_field, out_valid, out_last, count
  );
endinterface

// File: rtl/proc_field_serializer.sv
// Buffers packed words in a small FIFO and replays each one field per cycle, field 0 (MSBs) first.
// The head word keeps its slot until its last field transfers, so count covers a partly drained word.
module proc_field_serializer #(
  parameter int FIELD_W    = 2,
  parameter int NUM_FIELDS = 4,
  parameter int DEPTH      = 4
) (
  input logic                    clk,
  input logic                    rst,
  proc_field_serializer_if.slave bus
);
  localparam int W  = FIELD_W * NUM_FIELDS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [FW-1:0] LAST_IDX = FW'(NUM_FIELDS - 1);

  logic [W-1:0]       r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [FW-1:0]      r_fidx;
  logic [CW-1:0]      r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_out_last;
  logic               w_push;
  logic               w_xfer;
  logic               w_pop;
  logic [W-1:0]       w_head;
  logic [FIELD_W-1:0] w_field;

  // Ready depends on the registered count only; a pop at full frees the slot next cycle.
  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_out_last  = w_out_valid && (r_fidx == LAST_IDX);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_xfer      = w_out_valid && bus.out_ready;
  assign w_pop       = w_xfer && w_out_last;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_field = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (w_out_valid && (r_fidx == FW'(k))) begin
        w_field = w_head[W-1-k*FIELD_W -: FIELD_W];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_field = w_field;
  assign bus.count     = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fidx   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_fidx   <= '0;
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else if (w_xfer) begin
        r_fidx <= r_fidx + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
